alu_share_arb: RTL and testbench
================================

// Module: alu_share_arb
// PURPOSE
//  Shares one combinational alu instance between NREQ requesters (e.g. main issue
//  path and a branch/address helper) in the execute stage. Round-robin grants one
//  operand set per cycle, drives it onto the ALU and registers the ALU result
//  (res, brtaken) in a one-entry output stage with a valid/ready handshake.
// PARAMETERS
//  DWIDTH  32  data width of operands and result
//  AWIDTH  32  PC width
//  NREQ    2   number of requesters (>=2); id width IDW = $clog2(NREQ)
// PORTS
//  clk             in   1             clock, all state on rising edge
//  reset           in   1             asynchronous, active-high reset
//  req_valid_i     in   NREQ          requester i has an operation
//  req_ready_o     out  NREQ          requester i accepted this cycle (one-hot or 0)
//  req_pc_i        in   NREQ*AWIDTH   packed pc per requester, slot i = [i*AWIDTH +: AWIDTH]
//  req_rs1_i       in   NREQ*DWIDTH   packed rs1 operand per requester
//  req_rs2_i       in   NREQ*DWIDTH   packed rs2 operand per requester
//  req_funct3_i    in   NREQ*3        packed funct3 per requester
//  req_funct7_i    in   NREQ*7        packed funct7 per requester
//  alu_pc_o        out  AWIDTH        to alu pc_i (granted slot, else 0)
//  alu_rs1_o       out  DWIDTH        to alu rs1_i
//  alu_rs2_o       out  DWIDTH        to alu rs2_i
//  alu_funct3_o    out  3             to alu funct3_i
//  alu_funct7_o    out  7             to alu funct7_i
//  alu_res_i       in   DWIDTH        from alu res_o
//  alu_brtaken_i   in   1             from alu brtaken_o
//  res_valid_o     out  1             output stage holds a result
//  res_ready_i     in   1             consumer takes result this cycle
//  res_o           out  DWIDTH        registered ALU result
//  res_brtaken_o   out  1             registered branch-taken
//  res_id_o        out  IDW           requester index that produced res_o
// BEHAVIOUR
//  - Reset (async, any time incl. mid-hold): res_valid_o=0, res_o=0, res_brtaken_o=0,
//    res_id_o=0, rr pointer=0; any held result is discarded. req_ready_o comb => 0.
//  - Output stage FSM: EMPTY (res_valid_o=0) / FULL (res_valid_o=1).
//    can_accept = EMPTY | (FULL & res_ready_i)  (same-cycle drain+refill allowed).
//  - Arbitration (comb): search req_valid_i from index ptr upward, wrapping at NREQ;
//    first valid index g is granted. No valid -> no grant.
//  - req_ready_o[g]=1 only if grant exists and can_accept; all other bits 0.
//  - ALU drive: alu_* = slot g fields whenever a grant exists (even if not
//    accepted); all alu_* = 0 when no request valid.
//  - Accept (req_ready_o[g] & clk edge): res_o<=alu_res_i, res_brtaken_o<=alu_brtaken_i,
//    res_id_o<=g, res_valid_o<=1, ptr<=(g+1) mod NREQ. Latency accept->res_valid_o: 1 cycle.
//  - FULL & res_ready_i & no accept -> EMPTY. FULL & !res_ready_i -> hold all
//    res_* stable; ptr unchanged.
//  - ptr only advances on accept; requester granted but stalled keeps grant
//    next cycle (fairness: every continuously-valid requester served within NREQ accepts).
//  - Requester contract: fields stable while req_valid_i=1 && req_ready_o=0.
//  - Throughput: one result per cycle with res_ready_i held 1.
// TESTING
//  - Single: req0 rs1=5 rs2=3 f3=000 f7=0, res_ready=1 -> ready0 same cycle, next cycle
//    res_valid=1 res=8 id=0; then idle -> res_valid=0.
//  - Contention: req0 ADD(1,1), req1 SUB(f7=0x20,10,4) both held valid, res_ready=1 ->
//    results 2(id0), 6(id1), 2(id0), 6(id1) on consecutive cycles.
//  - Backpressure: accept req1 XOR(0xF0,0xFF), res_ready=0 3 cycles -> res=0x0F id=1
//    stable, req_ready_o=0; raise res_ready -> drain and accept waiting req same cycle.
//  - Reset mid-hold: FULL with res=0x0F, assert reset async mid-cycle -> res_valid_o=0,
//    res_o=0 immediately; after release first grant goes to req0 (ptr=0).
//  - Pointer wrap NREQ=3: only req2 valid -> id2, ptr=0; then req0,req1,req2 valid ->
//    order 0,1,2,0.
//  - SRA pass-through: rs1=0x80000000 rs2=4 f3=101 f7=0x20 -> res=0xF8000000.

Source files
------------

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters,
// with a one-entry registered result stage using a valid/ready handshake.
module alu_share_arb #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 32,
   parameter int NREQ   = 2,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid_i,
   output logic [NREQ-1:0]          req_ready_o,
   input  logic [NREQ*AWIDTH-1:0]   req_pc_i,
   input  logic [NREQ*DWIDTH-1:0]   req_rs1_i,
   input  logic [NREQ*DWIDTH-1:0]   req_rs2_i,
   input  logic [NREQ*3-1:0]        req_funct3_i,
   input  logic [NREQ*7-1:0]        req_funct7_i,
   output logic [AWIDTH-1:0]        alu_pc_o,
   output logic [DWIDTH-1:0]        alu_rs1_o,
   output logic [DWIDTH-1:0]        alu_rs2_o,
   output logic [2:0]               alu_funct3_o,
   output logic [6:0]               alu_funct7_o,
   input  logic [DWIDTH-1:0]        alu_res_i,
   input  logic                     alu_brtaken_i,
   output logic                     res_valid_o,
   input  logic                     res_ready_i,
   output logic [DWIDTH-1:0]        res_o,
   output logic                     res_brtaken_o,
   output logic [IDW-1:0]           res_id_o
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; ready never depends on anything registered downstream beyond
   // the output stage state, and a stalled requester must hold its fields.
   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [DWIDTH-1:0] res_q, res_d;
   logic              brtaken_q, brtaken_d;
   logic [IDW-1:0]    id_q, id_d;
   logic [IDW-1:0]    ptr_q, ptr_d;

   logic [AWIDTH-1:0] pc_slot  [NREQ];
   logic [DWIDTH-1:0] rs1_slot [NREQ];
   logic [DWIDTH-1:0] rs2_slot [NREQ];
   logic [2:0]        f3_slot  [NREQ];
   logic [6:0]        f7_slot  [NREQ];

   logic              grant_valid;
   logic [IDW-1:0]    grant_idx;
   logic [IDW-1:0]    cand_idx;
   logic              can_accept;
   logic              accept;

   for (genvar i = 0; i < NREQ; i++) begin : g_slot
      assign pc_slot[i]  = req_pc_i[i*AWIDTH +: AWIDTH];
      assign rs1_slot[i] = req_rs1_i[i*DWIDTH +: DWIDTH];
      assign rs2_slot[i] = req_rs2_i[i*DWIDTH +: DWIDTH];
      assign f3_slot[i]  = req_funct3_i[i*3 +: 3];
      assign f7_slot[i]  = req_funct7_i[i*7 +: 7];
   end

   // Search from the round-robin pointer upward, wrapping; first valid wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand_idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand_idx = IDW'((int'(ptr_q) + k) % NREQ);
         if (!grant_valid && req_valid_i[cand_idx]) begin
            grant_valid = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   assign can_accept  = (state_q == S_EMPTY) || res_ready_i;
   assign accept      = grant_valid && can_accept && !reset;
   assign req_ready_o = accept ? (NREQ'(1) << grant_idx) : '0;

   // The ALU sees the granted operands even when the output stage is stalled.
   always_comb begin
      alu_pc_o     = '0;
      alu_rs1_o    = '0;
      alu_rs2_o    = '0;
      alu_funct3_o = '0;
      alu_funct7_o = '0;
      if (grant_valid) begin
         alu_pc_o     = pc_slot[grant_idx];
         alu_rs1_o    = rs1_slot[grant_idx];
         alu_rs2_o    = rs2_slot[grant_idx];
         alu_funct3_o = f3_slot[grant_idx];
         alu_funct7_o = f7_slot[grant_idx];
      end
   end

   always_comb begin
      state_d   = state_q;
      res_d     = res_q;
      brtaken_d = brtaken_q;
      id_d      = id_q;
      ptr_d     = ptr_q;
      if (accept) begin
         state_d   = S_FULL;
         res_d     = alu_res_i;
         brtaken_d = alu_brtaken_i;
         id_d      = grant_idx;
         ptr_d     = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
      end else if (state_q == S_FULL && res_ready_i) begin
         state_d = S_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_EMPTY;
         res_q     <= '0;
         brtaken_q <= 1'b0;
         id_q      <= '0;
         ptr_q     <= '0;
      end else begin
         state_q   <= state_d;
         res_q     <= res_d;
         brtaken_q <= brtaken_d;
         id_q      <= id_d;
         ptr_q     <= ptr_d;
      end
   end

   assign res_valid_o   = (state_q == S_FULL);
   assign res_o         = res_q;
   assign res_brtaken_o = brtaken_q;
   assign res_id_o      = id_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with three requesters and a small
// reference ALU standing in for the shared execute unit.
module tb_alu_share_arb;

   localparam int NR = 3;

   logic            clk;
   logic            reset;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_ready;
   logic [NR*32-1:0] req_pc, req_rs1, req_rs2;
   logic [NR*3-1:0] req_f3;
   logic [NR*7-1:0] req_f7;
   logic [31:0]     alu_pc, alu_rs1, alu_rs2, alu_res;
   logic [2:0]      alu_f3;
   logic [6:0]      alu_f7;
   logic            alu_brtaken;
   logic            res_valid, res_ready, res_brtaken;
   logic [31:0]     res;
   logic [1:0]      res_id;

   logic [31:0] pc_a  [NR];
   logic [31:0] rs1_a [NR];
   logic [31:0] rs2_a [NR];
   logic [2:0]  f3_a  [NR];
   logic [6:0]  f7_a  [NR];

   int n_total = 0;
   int n_pass  = 0;
   logic [34:0] exp_q[$];

   for (genvar i = 0; i < NR; i++) begin : g_pack
      assign req_pc[i*32 +: 32]  = pc_a[i];
      assign req_rs1[i*32 +: 32] = rs1_a[i];
      assign req_rs2[i*32 +: 32] = rs2_a[i];
      assign req_f3[i*3 +: 3]    = f3_a[i];
      assign req_f7[i*7 +: 7]    = f7_a[i];
   end

   alu_share_arb #(.DWIDTH(32), .AWIDTH(32), .NREQ(NR)) dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_pc_i(req_pc), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
      .req_funct3_i(req_f3), .req_funct7_i(req_f7),
      .alu_pc_o(alu_pc), .alu_rs1_o(alu_rs1), .alu_rs2_o(alu_rs2),
      .alu_funct3_o(alu_f3), .alu_funct7_o(alu_f7),
      .alu_res_i(alu_res), .alu_brtaken_i(alu_brtaken),
      .res_valid_o(res_valid), .res_ready_i(res_ready),
      .res_o(res), .res_brtaken_o(res_brtaken), .res_id_o(res_id)
   );

   // Reference ALU: RV32I integer ops; brtaken stands in as rs1 == rs2.
   always_comb begin
      alu_res = '0;
      case (alu_f3)
         3'b000: if (alu_f7[5]) alu_res = alu_rs1 - alu_rs2;
                 else           alu_res = alu_rs1 + alu_rs2;
         3'b001: alu_res = alu_rs1 << alu_rs2[4:0];
         3'b010: alu_res = {31'b0, $signed(alu_rs1) < $signed(alu_rs2)};
         3'b011: alu_res = {31'b0, alu_rs1 < alu_rs2};
         3'b100: alu_res = alu_rs1 ^ alu_rs2;
         3'b101: if (alu_f7[5]) alu_res = $signed(alu_rs1) >>> alu_rs2[4:0];
                 else           alu_res = alu_rs1 >> alu_rs2[4:0];
         3'b110: alu_res = alu_rs1 | alu_rs2;
         default: alu_res = alu_rs1 & alu_rs2;
      endcase
      alu_brtaken = (alu_rs1 == alu_rs2);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic set_req(input int idx, input logic [31:0] pc, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [2:0] f3, input logic [6:0] f7);
      pc_a[idx]  = pc;
      rs1_a[idx] = rs1;
      rs2_a[idx] = rs2;
      f3_a[idx]  = f3;
      f7_a[idx]  = f7;
      req_valid[idx] = 1'b1;
   endtask

   task automatic clear_reqs();
      req_valid = '0;
      for (int i = 0; i < NR; i++) begin
         pc_a[i] = '0; rs1_a[i] = '0; rs2_a[i] = '0; f3_a[i] = '0; f7_a[i] = '0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_reqs();
      reset = 1'b1;
      #3;
      reset = 1'b0;
   endtask

   task automatic check_pkt(input string tag);
      logic [34:0] e;
      e = exp_q.pop_front();
      check({tag, "_valid"}, 64'(res_valid), 64'd1);
      check(tag, 64'({res_brtaken, res_id, res}), 64'(e));
   endtask

   initial begin
      reset = 1'b1;
      res_ready = 1'b0;
      clear_reqs();

      // Reset state
      @(negedge clk);
      check("rst_valid", 64'(res_valid), 64'd0);
      check("rst_res", 64'(res), 64'd0);
      check("rst_id", 64'(res_id), 64'd0);
      check("rst_brt", 64'(res_brtaken), 64'd0);
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_alu_pc", 64'(alu_pc), 64'd0);
      #3 reset = 1'b0;

      // Single request: ADD 5+3
      @(negedge clk);
      set_req(0, 32'h100, 32'd5, 32'd3, 3'b000, 7'h00);
      res_ready = 1'b1;
      #1;
      check("single_ready", 64'(req_ready), 64'b001);
      check("single_alu_pc", 64'(alu_pc), 64'h100);
      check("single_alu_rs1", 64'(alu_rs1), 64'd5);
      @(negedge clk);
      check("single_valid", 64'(res_valid), 64'd1);
      check("single_res", 64'(res), 64'd8);
      check("single_id", 64'(res_id), 64'd0);
      clear_reqs();
      #1 check("idle_alu_rs1", 64'(alu_rs1), 64'd0);
      @(negedge clk);
      check("single_drain", 64'(res_valid), 64'd0);

      // Contention: req0 ADD(1,1), req1 SUB(10,4)
      do_reset();
      @(negedge clk);
      set_req(0, 32'h10, 32'd1, 32'd1, 3'b000, 7'h00);
      set_req(1, 32'h20, 32'd10, 32'd4, 3'b000, 7'h20);
      res_ready = 1'b1;
      #1 check("cont_ready0", 64'(req_ready), 64'b001);
      exp_q.push_back({1'b1, 2'd0, 32'd2});
      exp_q.push_back({1'b0, 2'd1, 32'd6});
      exp_q.push_back({1'b1, 2'd0, 32'd2});
      exp_q.push_back({1'b0, 2'd1, 32'd6});
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_pkt("cont");
      end
      check("cont_q_empty", 64'(exp_q.size()), 64'd0);

      // Backpressure: hold XOR result while req0 waits
      do_reset();
      @(negedge clk);
      res_ready = 1'b0;
      set_req(1, 32'h44, 32'hF0, 32'hFF, 3'b100, 7'h00);
      #1 check("bp_ready1", 64'(req_ready), 64'b010);
      @(negedge clk);
      clear_reqs();
      set_req(0, 32'h40, 32'd2, 32'd3, 3'b000, 7'h00);
      #1;
      check("bp_stall_ready", 64'(req_ready), 64'b000);
      check("bp_stall_alu_rs1", 64'(alu_rs1), 64'd2);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_hold_valid", 64'(res_valid), 64'd1);
         check("bp_hold_res", 64'(res), 64'h0F);
         check("bp_hold_id", 64'(res_id), 64'd1);
         check("bp_hold_ready", 64'(req_ready), 64'b000);
      end
      res_ready = 1'b1;
      #1 check("bp_refill_ready", 64'(req_ready), 64'b001);
      @(negedge clk);
      check("bp_refill_valid", 64'(res_valid), 64'd1);
      check("bp_refill_res", 64'(res), 64'd5);
      check("bp_refill_id", 64'(res_id), 64'd0);
      clear_reqs();
      @(negedge clk);
      check("bp_drain", 64'(res_valid), 64'd0);

      // Reset in the middle of a hold
      do_reset();
      @(negedge clk);
      res_ready = 1'b0;
      set_req(1, 32'h44, 32'hF0, 32'hFF, 3'b100, 7'h00);
      @(negedge clk);
      check("mh_full_res", 64'(res), 64'h0F);
      clear_reqs();
      #2 reset = 1'b1;
      #1;
      check("mh_valid", 64'(res_valid), 64'd0);
      check("mh_res", 64'(res), 64'd0);
      check("mh_id", 64'(res_id), 64'd0);
      set_req(0, 32'h10, 32'd1, 32'd1, 3'b000, 7'h00);
      #1 check("mh_ready_in_rst", 64'(req_ready), 64'b000);
      clear_reqs();
      reset = 1'b0;
      @(negedge clk);
      res_ready = 1'b1;
      set_req(0, 32'h10, 32'd1, 32'd1, 3'b000, 7'h00);
      set_req(1, 32'h20, 32'd10, 32'd4, 3'b000, 7'h20);
      set_req(2, 32'h30, 32'h0F, 32'hF0, 3'b110, 7'h00);
      #1 check("mh_first_grant", 64'(req_ready), 64'b001);
      @(negedge clk);
      check("mh_first_id", 64'(res_id), 64'd0);
      clear_reqs();

      // Pointer wrap with three requesters
      do_reset();
      @(negedge clk);
      res_ready = 1'b1;
      set_req(2, 32'h30, 32'h0F, 32'hF0, 3'b110, 7'h00);
      @(negedge clk);
      check("wrap_valid", 64'(res_valid), 64'd1);
      check("wrap_id2", 64'(res_id), 64'd2);
      check("wrap_res", 64'(res), 64'hFF);
      set_req(0, 32'h10, 32'd1, 32'd1, 3'b000, 7'h00);
      set_req(1, 32'h20, 32'd10, 32'd4, 3'b000, 7'h20);
      exp_q.push_back({1'b1, 2'd0, 32'd2});
      exp_q.push_back({1'b0, 2'd1, 32'd6});
      exp_q.push_back({1'b0, 2'd2, 32'hFF});
      exp_q.push_back({1'b1, 2'd0, 32'd2});
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_pkt("wrap_order");
      end
      clear_reqs();

      // Arithmetic shift right passes through untouched
      do_reset();
      @(negedge clk);
      res_ready = 1'b1;
      set_req(0, 32'h50, 32'h8000_0000, 32'd4, 3'b101, 7'h20);
      #1 check("sra_alu_f7", 64'(alu_f7), 64'h20);
      @(negedge clk);
      check("sra_valid", 64'(res_valid), 64'd1);
      check("sra_res", 64'(res), 64'hF800_0000);
      check("sra_id", 64'(res_id), 64'd0);
      clear_reqs();
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
